// File: rtl/indata_pkg.sv
// Shared constants and FSM state type for the input-data stream reader.
package indata_pkg;
  localparam int unsigned INDATA_DEPTH  = 16;
  localparam int unsigned INDATA_ADDR_W = 4;
  localparam int unsigned INDATA_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/indata_stream_reader_if.sv
// Control, RAM read-port and output-stream signals of the stream reader.
interface indata_stream_reader_if
  import indata_pkg::*;
#(
  parameter int unsigned DATA_W = INDATA_DATA_W,
  parameter int unsigned ADDR_W = INDATA_ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   num_words;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, num_words, ram_dout, m_ready,
    output ram_en, ram_addr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, start_addr, num_words, ram_dout, m_ready,
    input  ram_en, ram_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/indata_skid_fifo.sv
// Two-entry FIFO with registered head; absorbs the one-cycle RAM read latency.
module indata_skid_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_occ
);
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  // A push into a full FIFO is only accepted together with a pop.
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_head  = r_head;
  assign o_occ   = r_occ;
endmodule

// File: rtl/indata_stream_reader.sv
// Reads a contiguous, wrapping run of words from the input-data RAM and streams them out.
module indata_stream_reader
  import indata_pkg::*;
#(
  parameter int unsigned DATA_W = INDATA_DATA_W,
  parameter int unsigned ADDR_W = INDATA_ADDR_W,
  parameter int unsigned DEPTH  = INDATA_DEPTH
) (
  input logic                    clk,
  input logic                    rst_n,
  indata_stream_reader_if.master bus
);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_start_addr;
  logic [ADDR_W:0]   r_num_words;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_accepted;
  logic              r_inflight;
  logic              r_inflight_last;

  logic              w_fifo_valid;
  logic [DATA_W:0]   w_fifo_head;
  logic [1:0]        w_occ;
  logic [1:0]        w_sum;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W:0]   w_nw;

  assign w_nw  = (bus.num_words > LP_DEPTH) ? LP_DEPTH : bus.num_words;
  assign w_pop = w_fifo_valid && bus.m_ready;
  assign w_sum = w_occ + {1'b0, r_inflight};

  // Slot accounting counts the read in flight, so a full FIFO only reissues on a pop.
  assign w_issue = (r_state == RUN) && (r_issued < r_num_words) &&
                   ((w_sum < 2'd2) || ((w_sum == 2'd2) && w_pop));
  assign w_issue_last = (r_issued == (r_num_words - LP_ONE));

  indata_skid_fifo #(.WIDTH(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_din   ({r_inflight_last, bus.ram_dout}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_head  (w_fifo_head),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_start_addr    <= '0;
      r_num_words     <= '0;
      r_issued        <= '0;
      r_accepted      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_issue_last;
      if (w_issue) r_issued   <= r_issued + LP_ONE;
      if (w_pop)   r_accepted <= r_accepted + LP_ONE;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_start_addr <= bus.start_addr;
            r_num_words  <= w_nw;
            r_issued     <= '0;
            r_accepted   <= '0;
            r_busy       <= 1'b1;
            if (w_nw == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_pop && w_fifo_head[DATA_W]) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ram_en   = w_issue;
  assign bus.ram_addr = r_start_addr + r_issued[ADDR_W-1:0];
  assign bus.m_valid  = w_fifo_valid;
  assign bus.m_data   = w_fifo_head[DATA_W-1:0];
  assign bus.m_last   = w_fifo_valid && w_fifo_head[DATA_W];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_indata_stream_reader.sv
// Scoreboard bench for indata_stream_reader: queued expectations, negedge monitor, RAM model.
module tb_indata_stream_reader;
  import indata_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  indata_stream_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  indata_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DP];
  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int en_cnt = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int first_valid = -1;
  int ready_mode = 0;
  bit prev_hold = 1'b0;
  logic [DW:0] prev_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every ram_en and every stream handshake against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_word", {bus.m_last, bus.m_data}, prev_word);
      end
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (bus.ram_en) begin
        en_cnt++;
        if (addr_q.size() == 0) check("ram_en_extra", bus.ram_en, 0);
        else check("ram_addr", bus.ram_addr, addr_q.pop_front());
      end
      if (bus.m_valid && bus.m_ready) begin
        logic [DW:0] w;
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("beat_extra", bus.m_valid, 0);
        end else begin
          w = exp_q.pop_front();
          check("m_data", bus.m_data, w[DW-1:0]);
          check("m_last", bus.m_last, w[DW]);
        end
      end
      if (bus.done) done_cnt++;
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_word = {bus.m_last, bus.m_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       bus.m_ready = ($urandom_range(0, 2) != 0);
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  task automatic push_expect(input int sa, input int nw);
    for (int k = 0; k < nw; k++) begin
      logic [AW-1:0] a;
      a = AW'((sa + k) % DP);
      addr_q.push_back(a);
      exp_q.push_back({(k == nw - 1), 32'hA000_0000 + 32'(a)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"},  bus.m_valid,  0);
    check({tag, "_m_last"},   bus.m_last,   0);
    check({tag, "_ram_en"},   bus.ram_en,   0);
    check({tag, "_ram_addr"}, bus.ram_addr, 0);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_done"},     bus.done,     0);
  endtask

  task automatic run(input int sa, input int nw, input int mode, input bit mid_start);
    int s_cyc;
    int done_c;
    int base_beats;
    bit seen;
    push_expect(sa, nw);
    ready_mode = mode;
    en_cnt = 0;
    first_valid = -1;
    base_beats = beat_cnt;
    seen = 1'b0;
    done_c = -1;
    @(posedge clk); #1;
    s_cyc = cyc;
    bus.start = 1'b1;
    bus.start_addr = AW'(sa);
    bus.num_words = (AW+1)'(nw);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      bus.start = mid_start && (i == 3);
      bus.start_addr = bus.start ? AW'(9) : AW'(sa);
      @(negedge clk);
      if (i == 0) begin
        check("busy_cycle1", bus.busy, 1);
        if (nw == 0) check("done_cycle1", bus.done, 1);
      end
      if (bus.done) begin
        seen = 1'b1;
        done_c = cyc;
      end
    end
    check("done_seen", seen, 1);
    check("ram_en_count", en_cnt, nw);
    check("beat_count", beat_cnt - base_beats, nw);
    check("exp_q_drained", exp_q.size(), 0);
    if (mode == 0) begin
      check("done_cycle", done_c - s_cyc, (nw == 0) ? 1 : nw + 3);
      if (nw > 0) check("first_valid_cycle", first_valid - s_cyc, 3);
      else        check("no_valid", first_valid, -1);
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    int base;
    int base_done;
    for (int i = 0; i < DP; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.num_words = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(2, 5, 0, 1'b0);
    run(14, 4, 0, 1'b0);
    run(0, 16, 1, 1'b0);
    run(5, 16, 2, 1'b0);
    run(7, 0, 0, 1'b0);
    run(3, 16, 0, 1'b1);
    run(11, 3, 0, 1'b0);
    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 2, 1'b0);

    // Reset in the middle of a run, three beats in.
    ready_mode = 0;
    base = beat_cnt;
    push_expect(4, 10);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = AW'(4);
    bus.num_words = (AW+1)'(10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 50 && (beat_cnt - base) < 3; i++) @(negedge clk);
    check("beats_before_reset", beat_cnt - base, 3);
    base_done = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    check("no_done_after_reset", done_cnt - base_done, 0);
    run(0, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
